md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit with the HI/LO registers for the 5-stage pipeline.
- Sits beside the ALU between the E-stage and M-stage pipeline registers.
- Takes rsE/rtE operands plus a decoded op. Runs a fixed-latency multi-cycle operation and commits the result to HI/LO.
- Raises Busy so the hazard unit stalls later MFHI/MFLO/mult/div instructions.

Parameters:
- MULT_CYCLES, 5, Busy cycles for MULT/MULTU (and MADD-family); legal 1..15.
- DIV_CYCLES, 10, Busy cycles for DIV/DIVU; legal 1..15.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Clr  in  1  synchronous active-high reset.
- Start  in  1  qualifies MdOp for one cycle; sampled on rising edge.
- MdOp  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; other codes reserved.
- A  in  32  operand rs (E-stage forwarded value).
- B  in  32  operand rt (E-stage forwarded value).
- HI  out  32  HI register.
- LO  out  32  LO register.
- Busy  out  1  operation in flight.

Behaviour:
- Reset: Clk and Clr as named; reset is synchronous, active-high. Clr=1 at an edge sets HI=0, LO=0, Busy=0, cycle counter=0 and pending result=0. Clr wins over Start in the same cycle. Clr during Busy aborts the operation; nothing is committed.
- States: IDLE, RUN.
- IDLE, Start=1, MdOp in {0..3} (or 6..9 when enabled):
  - Latch the full 64-bit result into an internal pending register.
  - Load counter with N-1: N=MULT_CYCLES for multiply-family ops, DIV_CYCLES for DIV/DIVU.
  - Go to RUN; Busy=1 from the next cycle.
- RUN: decrement counter each edge. At the edge where counter==0:
  - {HI,LO} <= pending, Busy <= 0, go to IDLE.
  - Busy is high for exactly N cycles. New HI/LO is visible in the cycle Busy first reads 0.
- Start=1 while Busy=1 is ignored: no restart, no HI/LO change. The hazard unit guarantees this does not happen; the verifier checks that it is ignored.
- MTHI/MTLO (Start=1 in IDLE): HI<=A or LO<=A at the same edge. Busy stays 0; no latency.
- Reserved MdOp, or 6..9 with the feature disabled: no state change, Busy stays 0.
- MULT: signed 32x32 -> 64; HI=upper, LO=lower.
- MULTU: unsigned 32x32 -> 64; HI=upper, LO=lower.
- DIV: signed. Quotient truncates toward zero; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned. LO=quotient, HI=remainder.
- B=0 for DIV/DIVU: Busy still runs DIV_CYCLES; HI/LO keep their prior values at commit.
- Operands are sampled only at Start. Later changes to A/B have no effect.
- HI/LO change only on commit, MTHI/MTLO, or Clr.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: MdOp 6..9 are legal with MULT_CYCLES latency. Using the current HI/LO at Start, the pending result is:
  - MADD: {HI,LO} + signed(A*B)
  - MADDU: {HI,LO} + unsigned(A*B)
  - MSUB: {HI,LO} - signed(A*B)
  - MSUBU: {HI,LO} - unsigned(A*B)
  - All modulo 2^64.
- Not defined: 6..9 are treated as reserved; no accumulate hardware is present.

Test Plan:
- Clr=1 for 2 cycles after random HI/LO writes -> HI=0, LO=0, Busy=0.
- MULT, A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=0x11, LO=0x22 preset via MTHI/MTLO, each visible the next cycle with Busy=0. Then DIVU B=0 -> Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- MULT started; Start=1 with DIVU on cycle 2 of Busy -> ignored; MULT result commits at cycle 5. A separate MULT with Clr=1 on cycle 3 -> Busy=0, HI=LO=0 next cycle, no later commit.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without MD_MADD_EN: MdOp=6 -> Busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning the HI/LO registers.
//
// A decoded op qualified by Start is evaluated on the spot. For multiply and
// divide ops the 64-bit result is parked in a pending register while Busy
// counts out a fixed latency, then committed to {HI,LO}. MTHI/MTLO write
// immediately.
//
// Build option: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (MdOp 6..9).
// Without it those codes are treated as reserved and no accumulate logic exists.
//
// Ports:
//   Clk   in   clock, rising edge
//   Clr   in   synchronous active-high clear
//   Start in   qualifies MdOp for one cycle
//   MdOp  in   op code (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6..9 MADD family)
//   A, B  in   operands rs/rt
//   HI,LO out  HI/LO registers
//   Busy  out  multi-cycle op in flight
//
// state | meaning
// IDLE  | no op in flight, accepts Start
// RUN   | counting down latency; commit pending result when counter hits 0

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Start,
  input  logic [3:0]  MdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N1 = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_N1  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_div, mag_q, mag_r;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case of a
  // native signed divider and gives truncation toward zero directly.
  assign a_mag = A[31] ? -A : A;
  assign b_mag = B[31] ? -B : B;
  // Divisor forced non-zero so the divider never sees 0; the result is
  // discarded in that case anyway.
  assign b_div = (B == 32'd0) ? 32'd1 : B;
  assign mag_q = a_mag / ((B == 32'd0) ? 32'd1 : b_mag);
  assign mag_r = a_mag % ((B == 32'd0) ? 32'd1 : b_mag);
  assign quo_s = (A[31] ^ B[31]) ? -mag_q : mag_q;
  assign rem_s = A[31] ? -mag_r : mag_r;
  assign quo_u = A / b_div;
  assign rem_u = A % b_div;

  logic        launch;
  logic [63:0] res;
  logic [3:0]  n_m1;

  always_comb begin
    launch = 1'b0;
    res    = pend_q;
    n_m1   = MULT_N1;
    case (MdOp)
      4'd0: begin launch = 1'b1; res = prod_s; end
      4'd1: begin launch = 1'b1; res = prod_u; end
      4'd2: begin
        launch = 1'b1;
        n_m1   = DIV_N1;
        res    = (B == 32'd0) ? {hi_q, lo_q} : {rem_s, quo_s};
      end
      4'd3: begin
        launch = 1'b1;
        n_m1   = DIV_N1;
        res    = (B == 32'd0) ? {hi_q, lo_q} : {rem_u, quo_u};
      end
`ifdef MD_MADD_EN
      4'd6: begin launch = 1'b1; res = {hi_q, lo_q} + prod_s; end
      4'd7: begin launch = 1'b1; res = {hi_q, lo_q} + prod_u; end
      4'd8: begin launch = 1'b1; res = {hi_q, lo_q} - prod_s; end
      4'd9: begin launch = 1'b1; res = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (launch) begin
            pend_d  = res;
            cnt_d   = n_m1;
            state_d = RUN;
          end else if (MdOp == 4'd4) begin
            hi_d = A;
          end else if (MdOp == 4'd5) begin
            lo_d = A;
          end
        end
      end
      RUN: begin
        // Start is deliberately not looked at here: a second op while busy is ignored.
        if (cnt_q == 4'd0) begin
          {hi_d, lo_d} = pend_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = (state_q == RUN);

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clk = 1'b0;
  logic        Clr, Start;
  logic [3:0]  MdOp;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        Busy;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .MdOp(MdOp), .A(A), .B(B),
    .HI(HI), .LO(LO), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          commit;
    logic [31:0] hi;
    logic [31:0] lo;
    int          nbusy;
    int          ready;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endfunction

  function automatic void push(bit commit, int nbusy, string nm);
    exp_t e;
    e.commit = commit;
    e.hi     = m_hi;
    e.lo     = m_lo;
    e.nbusy  = nbusy;
    e.ready  = cyc;
    e.name   = nm;
    q.push_back(e);
  endfunction

  // Reference model: architectural effect of one op on {HI,LO}.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit launch, output int n);
    longint sa, sb, qq, rr;
    longint unsigned ua, ub;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {m_hi, m_lo};
    launch = 1'b0;
    n = 0;
    case (op)
      4'd0: begin launch = 1; n = MC; acc = sa * sb; end
      4'd1: begin launch = 1; n = MC; acc = ua * ub; end
      4'd2: begin
        launch = 1; n = DC;
        if (b != 0) begin
          qq = sa / sb;
          rr = sa % sb;
          acc = {rr[31:0], qq[31:0]};
        end
      end
      4'd3: begin
        launch = 1; n = DC;
        if (b != 0) acc = {32'(ua % ub), 32'(ua / ub)};
      end
      4'd4: acc[63:32] = a;
      4'd5: acc[31:0] = a;
`ifdef MD_MADD_EN
      4'd6: begin launch = 1; n = MC; acc = acc + 64'(sa * sb); end
      4'd7: begin launch = 1; n = MC; acc = acc + 64'(ua * ub); end
      4'd8: begin launch = 1; n = MC; acc = acc - 64'(sa * sb); end
      4'd9: begin launch = 1; n = MC; acc = acc - 64'(ua * ub); end
`endif
      default: ;
    endcase
    {m_hi, m_lo} = acc;
  endtask

  // inj > 0: drive an extra DIVU Start on that Busy cycle; it must be ignored.
  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, string nm, int inj = 0);
    bit launch;
    int n;
    bit done;
    @(negedge Clk);
    Start = 1'b1; MdOp = op; A = a; B = b;
    model(op, a, b, launch, n);
    @(posedge Clk); #1;
    Start = 1'b0; MdOp = 4'($urandom); A = $urandom; B = $urandom;
    push(launch, n, nm);
    if (launch) begin
      done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge Clk);
        if (!Busy) begin done = 1'b1; break; end
        if (k == inj) begin
          Start = 1'b1; MdOp = 4'd3; A = $urandom; B = $urandom;
          @(posedge Clk); #1;
          Start = 1'b0;
        end
      end
      if (!done) begin
        n_chk++;
        $display("FAIL %s_timeout: Busy still 1 after 40 cycles, expected %0d", nm, n);
      end
    end
  endtask

  task automatic do_clr(int ncyc);
    @(negedge Clk);
    Clr = 1'b1; Start = 1'b1; MdOp = 4'd4; A = $urandom;
    repeat (ncyc) @(posedge Clk);
    #1;
    Clr = 1'b0; Start = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    push(1'b0, 0, "clr");
  endtask

  task automatic mult_abort();
    @(negedge Clk);
    Start = 1'b1; MdOp = 4'd0; A = 32'h1234_5678; B = 32'h9abc_def0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Clr = 1'b1;
    @(posedge Clk); #1;
    Clr = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    push(1'b0, 0, "abort_clr");
    repeat (12) @(negedge Clk);
    #1;
    push(1'b0, 0, "abort_no_commit");
  endtask

  // Monitor: compares at Busy fall (commits) or the cycle after an immediate op.
  initial begin
    bit pb;
    bit popped;
    int run;
    pb = 1'b0;
    run = 0;
    forever begin
      @(negedge Clk);
      popped = 1'b0;
      if (Busy) run++;
      while (q.size() > 0 && !q[0].commit && q[0].ready <= cyc) begin
        chk({q[0].name, "_hi"}, HI, q[0].hi);
        chk({q[0].name, "_lo"}, LO, q[0].lo);
        chk({q[0].name, "_busy"}, 32'(Busy), 32'd0);
        void'(q.pop_front());
        popped = 1'b1;
      end
      if (pb && !Busy) begin
        if (q.size() > 0 && q[0].commit) begin
          chk({q[0].name, "_hi"}, HI, q[0].hi);
          chk({q[0].name, "_lo"}, LO, q[0].lo);
          chk({q[0].name, "_busylen"}, 32'(run), 32'(q[0].nbusy));
          void'(q.pop_front());
        end else if (!popped) begin
          n_chk++;
          $display("FAIL spurious_commit: Busy fell after %0d cycles, expected no op in flight", run);
        end
      end
      if (!Busy) run = 0;
      pb = Busy;
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    Clr = 1'b1; Start = 1'b0; MdOp = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    Clr = 1'b0;
    push(1'b0, 0, "reset");

    issue(4'd4, $urandom, 0, "mthi_rand");
    issue(4'd5, $urandom, 0, "mtlo_rand");
    do_clr(2);

    issue(4'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, "multu");
    issue(4'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(4'd4, 32'h11, 0, "mthi");
    issue(4'd5, 32'h22, 0, "mtlo");
    issue(4'd3, 32'h1234, 32'd0, "divu_zero");
    issue(4'd0, 32'h0001_0003, 32'hFFFF_0007, "mult_inj", 2);
    mult_abort();

`ifdef MD_MADD_EN
    issue(4'd4, 32'd0, 0, "mthi0");
    issue(4'd5, 32'hFFFF_FFFF, 0, "mtlo1s");
    issue(4'd7, 32'd1, 32'd1, "maddu");
    issue(4'd6, 32'hFFFF_FFFD, 32'd7, "madd");
    issue(4'd8, 32'hFFFF_FFFD, 32'd7, "msub");
    issue(4'd9, 32'h8000_0001, 32'hFFFF_FFFF, "msubu");
`else
    issue(4'd4, 32'hA5A5_0001, 0, "mthi_pre");
    issue(4'd6, 32'd1, 32'd1, "madd_reserved");
`endif

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    repeat (3) @(negedge Clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
